regfile_mp: RTL and testbench



---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_mp.sv | 104 ++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, the address-width helper and the word and
// address types used by the multi-port register file.
package regfile_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;

   // Address width for a register file of n entries (at least one bit).
   function automatic int unsigned addr_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef logic [addr_width(NREGS_DEF)-1:0] reg_addr_t;
   typedef logic [XLEN_DEF-1:0]              xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per architectural register.
//   clk, rst      : clock, asynchronous active-high reset
//   clr_en/addr   : per write port, clear busy of the written register
//   rsv_valid/addr: reserve (set busy) a destination register
//   rd_addr       : per read port lookup address (flattened, port 0 in LSBs)
//   rd_busy       : per read port busy bit of rd_addr
//   rsv_conflict  : sticky, set when reserving a register that stays busy
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = addr_width(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NWR-1:0]    clr_en,
   input  logic [NWR*AW-1:0] clr_addr,
   input  logic              rsv_valid,
   input  logic [AW-1:0]     rsv_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   output logic [NRD-1:0]    rd_busy,
   output logic              rsv_conflict
);

   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic             conflict_nxt;
   logic             rsv_ok;
   logic             rsv_cleared;

   always_comb begin
      busy_nxt    = busy;
      rsv_cleared = 1'b0;
      for (int unsigned i = 0; i < NWR; i++) begin
         if (clr_en[i]) begin
            busy_nxt[clr_addr[i*AW +: AW]] = 1'b0;
            if (clr_addr[i*AW +: AW] == rsv_addr) rsv_cleared = 1'b1;
         end
      end
      rsv_ok = rsv_valid && !((ZERO_REG != 0) && (rsv_addr == '0));
      // Set after clear: the reserving instruction is the younger producer.
      if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
      conflict_nxt = rsv_conflict | (rsv_ok & busy[rsv_addr] & ~rsv_cleared);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy         <= '0;
         rsv_conflict <= 1'b0;
      end else begin
         busy         <= busy_nxt;
         rsv_conflict <= conflict_nxt;
      end
   end

   always_comb begin
      rd_busy = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
         rd_busy[j] = busy[rd_addr[j*AW +: AW]];
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with write-to-read
// bypass, optional hardwired zero register, busy-bit scoreboard and a
// debug read port. Vector ports are flattened, port 0 in the LSBs.
//   clk, rst     : clock, asynchronous active-high reset
//   we/waddr/wdata : NWR write ports
//   raddr/rdata/rready : NRD combinational read ports with operand-valid
//   rsv_valid/rsv_addr : destination reservation; rsv_conflict sticky error
//   dbg_addr/dbg_data  : debug read of array contents, never bypassed
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = addr_width(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NWR-1:0]      we,
   input  logic [NWR*AW-1:0]   waddr,
   input  logic [NWR*XLEN-1:0] wdata,
   input  logic [NRD*AW-1:0]   raddr,
   output logic [NRD*XLEN-1:0] rdata,
   output logic [NRD-1:0]      rready,
   input  logic                rsv_valid,
   input  logic [AW-1:0]       rsv_addr,
   output logic                rsv_conflict,
   input  logic [AW-1:0]       dbg_addr,
   output logic [XLEN-1:0]     dbg_data
);

   logic [XLEN-1:0] mem [NREGS];
   logic [NRD-1:0]  rd_busy;

   // Ports processed in ascending order so the highest index wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned k = 0; k < NREGS; k++) mem[k] <= '0;
      end else begin
         for (int unsigned i = 0; i < NWR; i++) begin
            if (we[i] && !((ZERO_REG != 0) && (waddr[i*AW +: AW] == '0)))
               mem[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
         end
      end
   end

   regfile_scoreboard #(
      .NREGS    (NREGS),
      .NRD      (NRD),
      .NWR      (NWR),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk          (clk),
      .rst          (rst),
      .clr_en       (we),
      .clr_addr     (waddr),
      .rsv_valid    (rsv_valid),
      .rsv_addr     (rsv_addr),
      .rd_addr      (raddr),
      .rd_busy      (rd_busy),
      .rsv_conflict (rsv_conflict)
   );

   logic [AW-1:0]   ra;
   logic            hit;
   logic [XLEN-1:0] byp;

   always_comb begin
      rdata  = '0;
      rready = '0;
      ra     = '0;
      hit    = 1'b0;
      byp    = '0;
      for (int unsigned j = 0; j < NRD; j++) begin
         ra  = raddr[j*AW +: AW];
         hit = 1'b0;
         byp = '0;
         if (BYPASS != 0) begin
            for (int unsigned i = 0; i < NWR; i++) begin
               if (we[i] && (waddr[i*AW +: AW] == ra)) begin
                  hit = 1'b1;
                  byp = wdata[i*XLEN +: XLEN];
               end
            end
         end
         rdata[j*XLEN +: XLEN] = hit ? byp : mem[ra];
         rready[j]             = ~rd_busy[j] | hit;
         // Zero register overrides any bypass of a dropped write.
         if ((ZERO_REG != 0) && (ra == '0)) begin
            rdata[j*XLEN +: XLEN] = '0;
            rready[j]             = 1'b1;
         end
      end
   end

   always_comb begin
      if ((ZERO_REG != 0) && (dbg_addr == '0)) dbg_data = '0;
      else                                     dbg_data = mem[dbg_addr];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp. u_dut uses two write ports,
// bypass and the zero register; u_nb has one write port, no bypass and no
// zero register.
module tb_regfile_mp;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst;

   logic [1:0]  we;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic [1:0]  rready;
   logic        rsv_valid;
   reg_addr_t   rsv_addr;
   logic        rsv_conflict;
   reg_addr_t   dbg_addr;
   xword_t      dbg_data;

   logic        nb_we;
   reg_addr_t   nb_waddr;
   xword_t      nb_wdata;
   logic [63:0] nb_rdata;
   logic [1:0]  nb_rready;
   logic        nb_rsv_valid;
   reg_addr_t   nb_rsv_addr;
   logic        nb_rsv_conflict;
   xword_t      nb_dbg_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_mp #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)
   ) u_dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr(raddr), .rdata(rdata), .rready(rready),
      .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_conflict(rsv_conflict),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   regfile_mp #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(1), .BYPASS(0), .ZERO_REG(0)
   ) u_nb (
      .clk(clk), .rst(rst), .we(nb_we), .waddr(nb_waddr), .wdata(nb_wdata),
      .raddr(raddr), .rdata(nb_rdata), .rready(nb_rready),
      .rsv_valid(nb_rsv_valid), .rsv_addr(nb_rsv_addr),
      .rsv_conflict(nb_rsv_conflict),
      .dbg_addr(dbg_addr), .dbg_data(nb_dbg_data)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we = 2'b00; waddr = '0; wdata = '0;
      rsv_valid = 1'b0; rsv_addr = '0;
      nb_we = 1'b0; nb_waddr = '0; nb_wdata = '0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      raddr = '0; dbg_addr = '0;
      nb_rsv_valid = 1'b0; nb_rsv_addr = '0;
      #8;
      chk("rst_conflict", {63'b0, rsv_conflict}, 64'd0);
      chk("rst_rready",   {62'b0, rready}, 64'd3);
      #4 rst = 1'b0;

      // 1: everything reads zero and ready after reset
      for (int a = 0; a < 32; a++) begin
         raddr = {5'(a), 5'(a)};
         dbg_addr = 5'(a);
         #1;
         chk("rst_rdata",  rdata, 64'd0);
         chk("rst_ready",  {62'b0, rready}, 64'd3);
         chk("rst_dbg",    {32'b0, dbg_data}, 64'd0);
      end
      tick();

      // 2: same-cycle bypass vs. next-cycle visibility
      raddr = {5'd0, 5'd1};
      we = 2'b01; waddr = {5'd0, 5'd1}; wdata = {32'd0, 32'd1};
      nb_we = 1'b1; nb_waddr = 5'd1; nb_wdata = 32'd1;
      #1;
      chk("byp_rdata",   {32'b0, rdata[31:0]}, 64'd1);
      chk("byp_rready",  {63'b0, rready[0]}, 64'd1);
      chk("nb_same_cyc", {32'b0, nb_rdata[31:0]}, 64'd0);
      tick();
      idle();
      #1;
      chk("wr_visible",  {32'b0, rdata[31:0]}, 64'd1);
      chk("nb_next_cyc", {32'b0, nb_rdata[31:0]}, 64'd1);

      // 3: register zero
      raddr = {5'd0, 5'd0}; dbg_addr = 5'd0;
      we = 2'b01; waddr = {5'd0, 5'd0}; wdata = {32'd0, 32'hDEAD};
      nb_we = 1'b1; nb_waddr = 5'd0; nb_wdata = 32'hDEAD;
      #1;
      chk("zero_byp",   {32'b0, rdata[31:0]}, 64'd0);
      chk("zero_ready", {63'b0, rready[0]}, 64'd1);
      tick();
      idle();
      #1;
      chk("zero_rdata", {32'b0, rdata[31:0]}, 64'd0);
      chk("zero_dbg",   {32'b0, dbg_data}, 64'd0);
      chk("nb_r0_rd",   {32'b0, nb_rdata[31:0]}, 64'h0000DEAD);
      chk("nb_r0_dbg",  {32'b0, nb_dbg_data}, 64'h0000DEAD);

      // 4: both write ports to address 5, port 1 wins
      raddr = {5'd0, 5'd5};
      we = 2'b11; waddr = {5'd5, 5'd5}; wdata = {32'd7, 32'd3};
      #1;
      chk("dual_byp", {32'b0, rdata[31:0]}, 64'd7);
      tick();
      idle();
      dbg_addr = 5'd5;
      #1;
      chk("dual_rd",  {32'b0, rdata[31:0]}, 64'd7);
      chk("dual_dbg", {32'b0, dbg_data}, 64'd7);

      // 5: reservation, bypass clears, same-cycle set wins
      rsv_valid = 1'b1; rsv_addr = 5'd2;
      tick();
      idle();
      raddr = {5'd5, 5'd2};
      #1;
      chk("busy_ready", {62'b0, rready}, 64'd2);
      we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'd0, 32'd3};
      #1;
      chk("clr_ready", {63'b0, rready[0]}, 64'd1);
      chk("clr_rdata", {32'b0, rdata[31:0]}, 64'd3);
      tick();
      idle();
      #1;
      chk("after_clr_ready", {63'b0, rready[0]}, 64'd1);
      chk("after_clr_rdata", {32'b0, rdata[31:0]}, 64'd3);
      rsv_valid = 1'b1; rsv_addr = 5'd2;
      we = 2'b01; waddr = {5'd0, 5'd2}; wdata = {32'd0, 32'd9};
      #1;
      chk("setclr_byp_rdy", {63'b0, rready[0]}, 64'd1);
      tick();
      idle();
      dbg_addr = 5'd2;
      #1;
      chk("setclr_busy",  {63'b0, rready[0]}, 64'd0);
      chk("setclr_rdata", {32'b0, rdata[31:0]}, 64'd9);
      chk("setclr_dbg",   {32'b0, dbg_data}, 64'd9);
      chk("setclr_noconf", {63'b0, rsv_conflict}, 64'd0);

      // reserving register zero is ignored, never conflicts
      rsv_valid = 1'b1; rsv_addr = 5'd0;
      tick();
      tick();
      idle();
      raddr = {5'd0, 5'd0};
      #1;
      chk("r0_rsv_ready", {62'b0, rready}, 64'd3);
      chk("r0_rsv_conf",  {63'b0, rsv_conflict}, 64'd0);

      // re-reserving a busy register that is written that cycle: no conflict
      rsv_valid = 1'b1; rsv_addr = 5'd6;
      tick();
      we = 2'b10; waddr = {5'd6, 5'd0}; wdata = {32'd11, 32'd0};
      tick();
      idle();
      raddr = {5'd0, 5'd6};
      #1;
      chk("rw_rsv_conf",  {63'b0, rsv_conflict}, 64'd0);
      chk("rw_rsv_busy",  {63'b0, rready[0]}, 64'd0);
      chk("rw_rsv_rdata", {32'b0, rdata[31:0]}, 64'd11);

      // 6: double reservation -> sticky conflict
      rsv_valid = 1'b1; rsv_addr = 5'd4;
      tick();
      #1;
      chk("rsv4_once", {63'b0, rsv_conflict}, 64'd0);
      tick();
      idle();
      tick();
      tick();
      #1;
      chk("rsv4_sticky", {63'b0, rsv_conflict}, 64'd1);

      // asynchronous reset mid-operation with pending write and reservation
      raddr = {5'd5, 5'd4}; dbg_addr = 5'd2;
      we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'd55};
      rsv_valid = 1'b1; rsv_addr = 5'd8;
      #1;
      chk("pre_rst_busy", {63'b0, rready[0]}, 64'd0);
      rst = 1'b1;
      #1;
      chk("arst_conf",  {63'b0, rsv_conflict}, 64'd0);
      chk("arst_ready", {62'b0, rready}, 64'd3);
      chk("arst_rdata", rdata, 64'd0);
      chk("arst_dbg",   {32'b0, dbg_data}, 64'd0);
      tick();
      idle();
      rst = 1'b0;
      raddr = {5'd8, 5'd7};
      #1;
      chk("rst_wr_drop",  {32'b0, rdata[31:0]}, 64'd0);
      chk("rst_rsv_drop", {62'b0, rready}, 64'd3);
      chk("rst_conf_low", {63'b0, rsv_conflict}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
